// File: rtl/n64_button_event_fifo.sv
// Timestamped FIFO of N64 controller button-change events, read and configured over APB3.
// Latency: an event reaches STATUS.count one cycle after sample_valid; PREADY is tied high.
module n64_button_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        sample_valid,
  input  logic [31:0] button_data,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        event_irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [6:0]    count;
  logic          ovf;
  logic [15:0]   ts, last, mask;
  logic          primed, irq_en, enable;

  logic       access, rd, wr, empty, full;
  logic [1:0] sel;
  logic       pop, flush, ovf_clr, ctrl_wr, samp, evt, push, ovf_set;

  assign access  = PSEL & PENABLE;
  assign rd      = access & ~PWRITE;
  assign wr      = access & PWRITE;
  assign sel     = PADDR[3:2];
  assign empty   = (count == 7'd0);
  assign full    = (count == 7'(DEPTH));

  assign pop     = rd & (sel == 2'd0) & ~empty;
  assign flush   = wr & (sel == 2'd3) & PWDATA[0];
  assign ovf_clr = wr & (sel == 2'd3) & PWDATA[1];
  assign ctrl_wr = wr & (sel == 2'd2);

  assign samp    = sample_valid & enable;
  assign evt     = samp & primed & (|((button_data[31:16] ^ last) & mask));
  // A flush or a same-cycle pop frees a slot, so only a truly full FIFO drops the event.
  assign push    = evt & (flush | ~full | pop);
  assign ovf_set = evt & ~flush & full & ~pop;

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ts     <= '0;
      last   <= '0;
      primed <= 1'b0;
      mask   <= 16'hFFFF;
      irq_en <= 1'b0;
      enable <= 1'b0;
    end else begin
      if (flush) begin
        rptr  <= '0;
        wptr  <= push ? AW'(1) : '0;
        count <= push ? 7'd1 : 7'd0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + 7'd1;
          2'b01:   count <= count - 7'd1;
          default: count <= count;
        endcase
      end
      // A dropped event in the same cycle as a clear keeps the sticky flag set.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (samp) begin
        ts     <= ts + 16'd1;
        last   <= button_data[31:16];
        primed <= 1'b1;
      end
      if (ctrl_wr) begin
        mask   <= PWDATA[15:0];
        irq_en <= PWDATA[16];
        enable <= PWDATA[17];
        if (PWDATA[17] & ~enable) primed <= 1'b0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[flush ? '0 : wptr] <= {button_data[31:16], ts};
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (sel)
        2'd0:    PRDATA = empty ? 32'd0 : mem[rptr];
        2'd1:    PRDATA = {15'd0, ovf, 6'd0, full, empty, 1'b0, count};
        2'd2:    PRDATA = {14'd0, enable, irq_en, mask};
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY    = 1'b1;
  assign PSLVERR   = rd & (sel == 2'd0) & empty;
  assign event_irq = irq_en & ~empty;

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:18], button_data[15:0]};

endmodule

// File: tb/tb_n64_button_event_fifo.sv
// Directed bench for n64_button_event_fifo with a reference model and a queue of expected event words.
module tb_n64_button_event_fifo;
  localparam int DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] button_data = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, event_irq;

  always #5 PCLK = ~PCLK;

  n64_button_event_fifo #(.DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .sample_valid(sample_valid), .button_data(button_data),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .event_irq(event_irq)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] q[$];
  logic        m_ovf = 1'b0, m_primed = 1'b0, m_irq = 1'b0, m_en = 1'b0;
  logic [15:0] m_ts = '0, m_last = '0, m_mask = 16'hFFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic empty_b, full_b;
    empty_b = (q.size() == 0);
    full_b  = (q.size() == DEPTH);
    return {15'd0, m_ovf, 6'd0, full_b, empty_b, 1'b0, 7'(q.size())};
  endfunction

  task automatic model_sample(input logic [31:0] bd);
    if (m_en) begin
      if (m_primed && ((bd[31:16] ^ m_last) & m_mask) != 16'd0) begin
        if (q.size() < DEPTH) q.push_back({bd[31:16], m_ts});
        else m_ovf = 1'b1;
      end
      m_last   = bd[31:16];
      m_primed = 1'b1;
      m_ts     = m_ts + 16'd1;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_primed = 0; m_irq = 0; m_en = 0;
    m_ts = 0; m_last = 0; m_mask = 16'hFFFF;
  endtask

  // One APB transfer; an optional controller sample lands in the access-phase cycle.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit sv, input logic [31:0] bd,
                     output logic [31:0] rdata, output logic err);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1; sample_valid = sv; button_data = bd;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    check("pready", {31'd0, PREADY}, 32'd1);
    @(posedge PCLK);
    #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; sample_valid = 0;
  endtask

  task automatic read_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic e;
    apb(1'b0, addr, 32'd0, 1'b0, 32'd0, d, e);
    check(tag, d, exp);
    check({tag, "_err"}, {31'd0, e}, 32'd0);
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data,
                           input bit sv, input logic [31:0] bd);
    logic [31:0] d; logic e;
    if (addr[3:2] == 2'd2) begin
      if (data[17] && !m_en) m_primed = 1'b0;
      m_mask = data[15:0]; m_irq = data[16]; m_en = data[17];
    end else if (addr[3:2] == 2'd3) begin
      if (data[0]) q.delete();
      if (data[1]) m_ovf = 1'b0;
    end
    if (sv) model_sample(bd);
    apb(1'b1, addr, data, sv, bd, d, e);
    check("wr_err", {31'd0, e}, 32'd0);
  endtask

  task automatic read_data(input bit sv, input logic [31:0] bd);
    logic [31:0] d, exp; logic e, exp_err;
    if (q.size() > 0) begin exp = q.pop_front(); exp_err = 0; end
    else begin exp = 32'd0; exp_err = 1; end
    if (sv) model_sample(bd);
    apb(1'b0, 32'h0, 32'd0, sv, bd, d, e);
    check("data", d, exp);
    check("data_err", {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic do_sample(input logic [31:0] bd);
    model_sample(bd);
    @(negedge PCLK);
    sample_valid = 1; button_data = bd;
    @(posedge PCLK);
    #1 sample_valid = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) do_sample({m_last + 16'd1, 16'(i * 7)});
  endtask

  task automatic check_status(input string tag);
    read_reg(tag, 32'h4, exp_status());
  endtask

  task automatic pulse_reset();
    @(negedge PCLK);
    PRESERN = 0;
    @(posedge PCLK);
    #1;
    model_reset();
    check("rst_irq", {31'd0, event_irq}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd1);
    PRESERN = 1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge PCLK);
    pulse_reset();
    read_reg("status_rst", 32'h4, 32'h0000_0100);
    read_reg("ctrl_rst", 32'h8, 32'h0000_FFFF);

    // Single event: baseline sample, then bit 31 press
    write_reg(32'h8, 32'h0003_FFFF, 0, 0);
    do_sample(32'h0000_1234);
    check("no_evt_prime", {31'd0, event_irq}, 32'd0);
    do_sample(32'h8000_5678);
    check("irq_latency", {31'd0, event_irq}, 32'd1);
    read_reg("status_one", 32'h4, 32'h0000_0001);
    read_data(0, 0);
    read_reg("status_drained", 32'h4, 32'h0000_0100);
    check("irq_clear", {31'd0, event_irq}, 32'd0);

    // Masking: bit 31 change ignored, bit 16 change counted
    write_reg(32'h8, 32'h0003_00FF, 0, 0);
    do_sample(32'h0000_ABCD);
    check_status("mask_hi_noevt");
    do_sample(32'h0001_ABCD);
    check_status("mask_lo_evt");
    read_data(0, 0);

    // Empty DATA read, no-op writes, CLEAR reads zero
    read_data(0, 0);
    read_reg("status_empty", 32'h4, 32'h0000_0100);
    write_reg(32'h0, 32'hFFFF_FFFF, 0, 0);
    write_reg(32'h4, 32'hFFFF_FFFF, 0, 0);
    check_status("status_noop_wr");
    read_reg("clear_rd", 32'hC, 32'h0);

    // Overflow: nine events into eight entries
    write_reg(32'h8, 32'h0003_FFFF, 0, 0);
    fill(DEPTH + 1);
    read_reg("status_ovf", 32'h4, 32'h0001_0208);
    for (int i = 0; i < DEPTH; i++) read_data(0, 0);
    read_reg("status_ovf_empty", 32'h4, 32'h0001_0100);
    write_reg(32'hC, 32'h2, 0, 0);
    read_reg("status_ovf_clr", 32'h4, 32'h0000_0100);

    // Full FIFO: pop and event on the same edge
    fill(DEPTH);
    read_reg("status_full", 32'h4, 32'h0000_0208);
    read_data(1, {m_last + 16'd1, 16'h0});
    read_reg("status_pushpop", 32'h4, 32'h0000_0208);
    for (int i = 0; i < DEPTH; i++) read_data(0, 0);

    // Flush with a simultaneous push
    fill(3);
    write_reg(32'hC, 32'h1, 1, {m_last + 16'd1, 16'h0});
    read_reg("status_flush_push", 32'h4, 32'h0000_0001);
    read_data(0, 0);

    // Overflow clear racing a dropped event
    fill(DEPTH);
    write_reg(32'hC, 32'h2, 1, {m_last + 16'd1, 16'h0});
    read_reg("status_ovf_race", 32'h4, 32'h0001_0208);
    write_reg(32'hC, 32'h3, 0, 0);
    check_status("status_flush_clr");

    // Disabled samples leave timestamp and baseline alone
    write_reg(32'h8, 32'h0000_FFFF, 0, 0);
    do_sample(32'h1111_0000);
    do_sample(32'h2222_0000);
    check_status("disabled_noevt");
    write_reg(32'h8, 32'h0003_FFFF, 0, 0);
    do_sample(32'h3333_0000);
    do_sample(32'h4444_0000);
    read_data(0, 0);

    // Reset mid-operation discards queued events
    fill(3);
    read_reg("status_three", 32'h4, 32'h0000_0003);
    pulse_reset();
    read_reg("status_after_rst", 32'h4, 32'h0000_0100);
    read_reg("ctrl_after_rst", 32'h8, 32'h0000_FFFF);
    check("irq_after_rst", {31'd0, event_irq}, 32'd0);
    read_data(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
